// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin scheduler, registered one-hot grant + index; ARB_TIMEOUT_EN adds forced release after MAX_HOLD cycles
module rr_grant_sched #(
  parameter int N = 8,
  parameter int IDXW = $clog2(N)
`ifdef ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic            rel,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [IDXW-1:0] ptr, ptr_n, win, k, idx_n;
  logic [N-1:0] grant_n;
  logic found, valid_n, done, forced;
`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  assign forced = hold_cnt == HW'(MAX_HOLD - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= state == BUSY ? hold_cnt + 1'b1 : '0;
      timeout  <= state == BUSY && forced && !rel && req[grant_idx];
    end
  end
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = ptr + IDXW'(i);
      if (!found && req[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    idx_n   = grant_idx;
    valid_n = grant_valid;
    done    = rel || !req[grant_idx] || forced;
    if (state == IDLE && en && found) begin
      state_n = BUSY;
      grant_n = N'(1) << win;
      idx_n   = win;
      valid_n = 1'b1;
    end else if (state == BUSY && done) begin
      state_n = IDLE;
      grant_n = '0;
      idx_n   = '0;
      valid_n = 1'b0;
      ptr_n   = grant_idx + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      grant_idx   <= idx_n;
      grant_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_rr_grant_sched.sv
// tb_rr_grant_sched: directed and random checks of rr_grant_sched against a behavioural model
module tb_rr_grant_sched;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic rst_n, en, rel;
  logic [7:0] req, grant;
  logic [2:0] grant_idx;
  logic grant_valid, timeout;
  int tests = 0, fails = 0;
  bit m_busy = 0, m_to = 0;
  int m_owner = 0, m_ptr = 0, m_held = 0;

  rr_grant_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .rel(rel),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic lit(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit forced;
`ifdef ARB_TIMEOUT_EN
    forced = m_held == MAX_HOLD - 1;
`else
    forced = 0;
`endif
    m_to = 0;
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_held = 0;
    end else if (!m_busy) begin
      if (en && req != 0) begin
        for (int j = 0; j < 8; j++)
          if (req[(m_ptr + j) % 8]) begin
            m_owner = (m_ptr + j) % 8;
            break;
          end
        m_busy = 1;
        m_held = 0;
      end
    end else if (rel || !req[m_owner] || forced) begin
      m_to = forced && !rel && req[m_owner];
      m_busy = 0;
      m_ptr = (m_owner + 1) % 8;
    end else begin
      m_held++;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input logic [7:0] q, input bit l);
    rst_n = r; en = e; req = q; rel = l;
    @(posedge clk);
    #1;
    model_step();
    lit("grant", grant, m_busy ? (1 << m_owner) : 0);
    lit("grant_idx", grant_idx, m_busy ? m_owner : 0);
    lit("grant_valid", grant_valid, m_busy);
    lit("timeout", timeout, m_to);
  endtask

  initial begin
    logic [31:0] r;
    bit e, l;
    logic [7:0] q;
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'hFF, 0);
    lit("reset_valid", grant_valid, 0);
    lit("reset_grant", grant, 0);
    cyc(1, 1, 8'h10, 0);
    lit("single_grant", grant, 8'h10);
    lit("single_idx", grant_idx, 4);
    cyc(1, 1, 8'h10, 1);
    lit("single_rel", grant_valid, 0);
    cyc(1, 1, 8'h10, 0);
    lit("single_regrant", grant_idx, 4);
    cyc(1, 1, 8'h00, 0);
    cyc(1, 1, 8'h09, 0);
    lit("skip_first", grant_idx, 0);
    cyc(1, 1, 8'h09, 1);
    cyc(1, 1, 8'h09, 0);
    lit("skip_second", grant_idx, 3);
    cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, 8'hFF, 0);
      lit("rotate_idx", grant_idx, i % 8);
      cyc(1, 1, 8'hFF, 1);
    end
    cyc(0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h01, 0);
    lit("en_block", grant_valid, 0);
    cyc(1, 1, 8'h01, 1);
    lit("en_grant", grant, 8'h01);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h01, 0);
    lit("en_hold", grant_valid, 1);
    cyc(1, 0, 8'h00, 0);
    lit("en_drop", grant_valid, 0);
    cyc(1, 1, 8'hFF, 0);
    cyc(0, 1, 8'hFF, 0);
    lit("rst_mid_valid", grant_valid, 0);
    lit("rst_mid_idx", grant_idx, 0);
    cyc(1, 1, 8'h02, 0);
    for (int i = 1; i < MAX_HOLD; i++) cyc(1, 1, 8'h02, 0);
    lit("hold_last", grant, 8'h02);
    cyc(1, 1, 8'h02, 0);
`ifdef ARB_TIMEOUT_EN
    lit("timeout_pulse", timeout, 1);
    lit("timeout_drop", grant_valid, 0);
    cyc(1, 0, 8'h02, 0);
    lit("timeout_once", timeout, 0);
`else
    lit("no_timeout", timeout, 0);
    lit("held_forever", grant, 8'h02);
`endif
    q = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if (r[1:0] == 0) q = r[31] ? r[15:8] : r[15:8] & r[23:16] & r[30:24];
      e = r[3:2] != 0;
      l = r[6:4] == 0;
      cyc(r[12:7] != 0, e, q, l);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
